video_text_controller: RTL and testbench

- Downstream consumer of the memory controller's video RAM write port (video_ram_addr/data/we).
- Owns an 80x25 text-cell buffer and scans it out as 640x400 @ 70 Hz VGA, using an external 8x16 font ROM.
- Each cell word: [7:0] character code, [15:8] attribute ([11:8] foreground, [15:12] background, 16-colour IRGB).

---
 rtl/video_text_controller.sv | 197 +++++++++++++++++++
 tb/tb_video_text_controller.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/video_text_controller.sv
// 80x25 text-mode VGA controller: cell RAM fed by the memory controller's
// video write port, scanned out as 640x400 @ 70 Hz through an external 8x16 font ROM.
module video_text_controller #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned COLS    = 80,
    parameter int unsigned ROWS    = 25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] video_ram_addr,
    input  logic [15:0] video_ram_data,
    input  logic        video_ram_we,
    output logic [11:0] font_addr,
    input  logic [7:0]  font_data,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hsync,
    output logic        vga_vsync
);

    localparam int unsigned DIV_W        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned CELLS        = COLS * ROWS;
    localparam int unsigned CELL_AW      = $clog2(CELLS);
    localparam int unsigned H_ACTIVE     = 640;
    localparam int unsigned H_SYNC_START = 656;
    localparam int unsigned H_SYNC_END   = 752;
    localparam int unsigned H_TOTAL      = 800;
    localparam int unsigned V_ACTIVE     = 400;
    localparam int unsigned V_SYNC_START = 412;
    localparam int unsigned V_SYNC_END   = 414;
    localparam int unsigned V_TOTAL      = 449;

    // IRGB component level: base 0xA when the colour bit is set, plus 0x5 for intensity.
    function automatic logic [3:0] level(input logic c, input logic i);
        level = (c ? 4'hA : 4'h0) + (i ? 4'h5 : 4'h0);
    endfunction

    logic [DIV_W-1:0] div_q;
    logic             pix_en_c;
    logic [9:0]       h_cnt_q, h_cnt_d;
    logic [8:0]       v_cnt_q, v_cnt_d;

    logic             act_c, hs_c, vs_c;
    logic [11:0]      rd_idx_c;

    logic [15:0]      cell_mem [CELLS];

    // S1 registers: cell word plus position info carried alongside it.
    logic [15:0]      s1_cell_q;
    logic [3:0]       s1_row_q;
    logic [2:0]       s1_bit_q;
    logic             s1_act_q, s1_hs_q, s1_vs_q;

    // S2 registers: font lookup in flight, attribute and position info.
    logic [11:0]      font_addr_q;
    logic [7:0]       s2_attr_q;
    logic [2:0]       s2_bit_q;
    logic             s2_act_q, s2_hs_q, s2_vs_q;

    // S3 output registers.
    logic [11:0]      rgb_q, rgb_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;

    logic             pix_on_c;
    logic [3:0]       colour_c;

    assign pix_en_c = (div_q == DIV_W'(CLK_DIV - 1));

    // Pixel-tick divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else if (pix_en_c) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    // Next raster position.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_en_c) begin
            if (h_cnt_q == 10'(H_TOTAL - 1)) begin
                h_cnt_d = '0;
                if (v_cnt_q == 9'(V_TOTAL - 1)) begin
                    v_cnt_d = '0;
                end else begin
                    v_cnt_d = v_cnt_q + 9'd1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    // Raster counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Timing flags and cell index for the current raster position.
    always_comb begin
        act_c    = (h_cnt_q < 10'(H_ACTIVE)) && (v_cnt_q < 9'(V_ACTIVE));
        hs_c     = (h_cnt_q >= 10'(H_SYNC_START)) && (h_cnt_q < 10'(H_SYNC_END));
        vs_c     = (v_cnt_q >= 9'(V_SYNC_START)) && (v_cnt_q < 9'(V_SYNC_END));
        rd_idx_c = 12'(v_cnt_q[8:4]) * 12'(COLS) + 12'(h_cnt_q[9:3]);
    end

    // Cell RAM write port; runs every clk, out-of-range addresses dropped.
    always_ff @(posedge clk) begin
        if (video_ram_we && (video_ram_addr < 12'(CELLS))) begin
            cell_mem[video_ram_addr[CELL_AW-1:0]] <= video_ram_data;
        end
    end

    // S0 read (read-first against a same-clk write) and S1 font address issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_cell_q   <= '0;
            s1_row_q    <= '0;
            s1_bit_q    <= '0;
            s1_act_q    <= 1'b0;
            s1_hs_q     <= 1'b0;
            s1_vs_q     <= 1'b0;
            font_addr_q <= '0;
            s2_attr_q   <= '0;
            s2_bit_q    <= '0;
            s2_act_q    <= 1'b0;
            s2_hs_q     <= 1'b0;
            s2_vs_q     <= 1'b0;
        end else if (pix_en_c) begin
            s1_cell_q   <= (rd_idx_c < 12'(CELLS)) ? cell_mem[rd_idx_c[CELL_AW-1:0]] : 16'h0000;
            s1_row_q    <= v_cnt_q[3:0];
            s1_bit_q    <= h_cnt_q[2:0];
            s1_act_q    <= act_c;
            s1_hs_q     <= hs_c;
            s1_vs_q     <= vs_c;
            font_addr_q <= {s1_cell_q[7:0], s1_row_q};
            s2_attr_q   <= s1_cell_q[15:8];
            s2_bit_q    <= s1_bit_q;
            s2_act_q    <= s1_act_q;
            s2_hs_q     <= s1_hs_q;
            s2_vs_q     <= s1_vs_q;
        end
    end

    // S2: pick the glyph bit and resolve foreground/background colour.
    always_comb begin
        pix_on_c = font_data[3'd7 - s2_bit_q];
        colour_c = pix_on_c ? s2_attr_q[3:0] : s2_attr_q[7:4];
    end

    // S3 next values: blank outside the active area, sync polarities applied here.
    always_comb begin
        rgb_d   = rgb_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        if (pix_en_c) begin
            rgb_d   = s2_act_q ? {level(colour_c[2], colour_c[3]),
                                  level(colour_c[1], colour_c[3]),
                                  level(colour_c[0], colour_c[3])} : 12'h000;
            hsync_d = ~s2_hs_q;
            vsync_d = s2_vs_q;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q   <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b0;
        end else begin
            rgb_q   <= rgb_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign font_addr = font_addr_q;
    assign vga_r     = rgb_q[11:8];
    assign vga_g     = rgb_q[7:4];
    assign vga_b     = rgb_q[3:0];
    assign vga_hsync = hsync_q;
    assign vga_vsync = vsync_q;

endmodule

// File: tb/tb_video_text_controller.sv
// Scoreboard bench for video_text_controller: a raster-level reference model pushes
// the expected {rgb, hsync, vsync} per pixel tick; a monitor pops and compares.
module tb_video_text_controller;

    localparam int CLK_DIV = 2;
    localparam logic [13:0] RST_ENT = 14'h0002;   // rgb 0, hsync 1, vsync 0

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] video_ram_addr;
    logic [15:0] video_ram_data;
    logic        video_ram_we;
    logic [11:0] font_addr;
    logic [7:0]  font_data;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hsync, vga_vsync;

    int checks   = 0;
    int failures = 0;

    video_text_controller #(.CLK_DIV(CLK_DIV)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .video_ram_addr (video_ram_addr),
        .video_ram_data (video_ram_data),
        .video_ram_we   (video_ram_we),
        .font_addr      (font_addr),
        .font_data      (font_data),
        .vga_r          (vga_r),
        .vga_g          (vga_g),
        .vga_b          (vga_b),
        .vga_hsync      (vga_hsync),
        .vga_vsync      (vga_vsync)
    );

    always #5 clk = ~clk;

    // Font ROM model with directed glyphs for 0x59 and 0xDB.
    function automatic logic [7:0] font_fn(input logic [7:0] ch, input logic [3:0] row);
        if (ch == 8'h59) return 8'h18;
        if (ch == 8'hDB) return (row < 4'd8) ? 8'hFF : 8'h00;
        return 8'(ch * 8'd13 + {4'd0, row} * 8'd29) ^ 8'h3C;
    endfunction

    assign font_data = font_fn(font_addr[11:4], font_addr[3:0]);

    function automatic logic [3:0] lvl(input logic c, input logic i);
        int v;
        v = (c ? 10 : 0) + (i ? 5 : 0);
        return 4'(v);
    endfunction

    logic [15:0] cells [2000];

    // Expected output for raster position (h, v), straight from the timing/colour rules.
    function automatic logic [13:0] expect_at(input int h, input int v);
        logic [15:0] cw;
        logic [7:0]  g;
        logic [3:0]  col;
        logic [11:0] rgb;
        logic        hs_n, vs;
        hs_n = !(h >= 656 && h < 752);
        vs   = (v >= 412 && v < 414);
        rgb  = 12'h000;
        if (h < 640 && v < 400) begin
            cw  = cells[(v / 16) * 80 + h / 8];
            g   = font_fn(cw[7:0], 4'(v % 16));
            col = g[7 - (h % 8)] ? cw[11:8] : cw[15:12];
            rgb = {lvl(col[2], col[3]), lvl(col[1], col[3]), lvl(col[0], col[3])};
        end
        return {rgb, hs_n, vs};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: raster position, cell contents, expected-output queue.
    logic [13:0] exp_q[$];
    int          m_div = 0, m_h = 0, m_v = 0;
    logic        pix_flag = 1'b0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_div = 0; m_h = 0; m_v = 0;
            pix_flag = 1'b0;
            exp_q.delete();
            exp_q.push_back(RST_ENT);
            exp_q.push_back(RST_ENT);
            if (clk && video_ram_we && video_ram_addr < 12'd2000)
                cells[video_ram_addr] = video_ram_data;
        end else begin
            if (m_div == CLK_DIV - 1) begin
                exp_q.push_back(expect_at(m_h, m_v));
                m_h++;
                if (m_h == 800) begin
                    m_h = 0;
                    m_v = (m_v == 448) ? 0 : m_v + 1;
                end
                m_div = 0;
                pix_flag = 1'b1;
            end else begin
                m_div++;
                pix_flag = 1'b0;
            end
            if (video_ram_we && video_ram_addr < 12'd2000)
                cells[video_ram_addr] = video_ram_data;
        end
    end

    // Monitor: one comparison per pixel tick, plus hsync pulse width and period.
    logic seen_590 = 1'b0;
    int   hs_low = 0, hs_period = 0, hs_runs = 0;
    logic have_fall = 1'b0, prev_hs = 1'b1;

    initial forever begin
        logic [13:0] e;
        @(negedge clk);
        if (!rst_n) begin
            hs_low = 0; hs_period = 0; have_fall = 1'b0; prev_hs = 1'b1;
        end else begin
            if (font_addr == 12'h590) seen_590 = 1'b1;
            if (pix_flag) begin
                if (exp_q.size() == 0) begin
                    chk("queue_empty", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("pixel", {18'd0, vga_r, vga_g, vga_b, vga_hsync, vga_vsync}, {18'd0, e});
                end
                hs_period++;
                if (!vga_hsync) begin
                    if (prev_hs) begin
                        if (have_fall) chk("hsync_period", 32'(hs_period), 32'd800);
                        have_fall = 1'b1;
                        hs_period = 0;
                    end
                    hs_low++;
                end else if (hs_low > 0) begin
                    chk("hsync_width", 32'(hs_low), 32'd96);
                    hs_runs++;
                    hs_low = 0;
                end
                prev_hs = vga_hsync;
            end
        end
    end

    task automatic rand_write();
        int a;
        a = 1 + int'($urandom % 2047);
        if (a == 81) a = 82;
        video_ram_we   = 1'b1;
        video_ram_addr = 12'(a);
        video_ram_data = 16'($urandom);
    endtask

    // Run with random traffic until the next pixel tick will scan (th, tv).
    task automatic run_until(input int th, input int tv, input int max_clk);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            video_ram_we = 1'b0;
            if (m_div == CLK_DIV - 1 && m_h == th && m_v == tv) break;
            if (n >= max_clk) begin
                chk("run_until_timeout", 32'(n), 32'(max_clk + 1));
                break;
            end
            n++;
            if ($urandom % 8 == 0) rand_write();
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rgb"}, {20'd0, vga_r, vga_g, vga_b}, 32'd0);
        chk({tag, "_hsync"}, {31'd0, vga_hsync}, 32'd1);
        chk({tag, "_vsync"}, {31'd0, vga_vsync}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        video_ram_we = 1'b0;
        video_ram_addr = '0;
        video_ram_data = '0;
        repeat (5) @(negedge clk);
        chk_reset_outputs("reset");

        // Preload rows 0..2 while still in reset, with directed cells 0 and 81.
        for (int i = 0; i < 240; i++) begin
            @(negedge clk);
            video_ram_we   = 1'b1;
            video_ram_addr = 12'(i);
            video_ram_data = (i == 0) ? 16'h0759 : (i == 81) ? 16'h1FDB : 16'($urandom);
        end
        @(negedge clk);
        video_ram_addr = 12'd2000;
        video_ram_data = 16'hFFFF;
        @(negedge clk);
        video_ram_we = 1'b0;
        chk_reset_outputs("reset_hold");
        rst_n = 1'b1;

        // Write cell 0 in the same clk as the scan read of (0,1).
        run_until(0, 1, 4000);
        video_ram_we   = 1'b1;
        video_ram_addr = 12'd0;
        video_ram_data = 16'h4C59;
        @(negedge clk);
        video_ram_we = 1'b0;

        // Mid-line reset, then restart from (0,0).
        run_until(300, 32, 60000);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midline_reset");
        repeat (5) @(negedge clk);
        chk_reset_outputs("midline_hold");
        rst_n = 1'b1;
        run_until(0, 2, 5000);
        repeat (8) @(negedge clk);

        chk("font_addr_590_seen", {31'd0, seen_590}, 32'd1);
        chk("hsync_runs_seen", {31'd0, hs_runs > 30}, 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global bound on run length.
    initial begin
        repeat (95000) @(posedge clk);
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
